// File: rtl/bcm_scan_ctrl.sv
// rtl/bcm_scan_ctrl.sv - BCM scan sequencer between the pixel loader and the LED matrix pins
//
// Fetches BYTES_PER_ROW packed bytes per (row, bit-plane) from the loader, shifts
// them out LSB first, latches the row and holds OE for BASE_TICKS << plane clocks.
// Loading of the next plane overlaps the OE period of the current one.
//
// Optional feature: define BCM_LOAD_TIMEOUT_EN to add a 6-bit loader watchdog in
// WAIT; on expiry load_error sets (sticky) and a zero byte is shifted instead.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   enable              run scan, sampled only at frame boundaries
//   frame_offset[10:0]  pixel offset added to loader addresses, sampled at frame start
//   ld_load_rq          loader request (one-cycle pulse)
//   ld_bit[3:0]         bit-plane index for the loader
//   ld_address[10:0]    first pixel address of the requested byte
//   ld_data_ready       loader completion level, rising edge = data valid
//   ld_data_out[7:0]    packed plane bits, bit0 = leftmost pixel
//   sclk, sdata, latch  column shift clock, serial data, latch strobe
//   oe_n                output enable, active low
//   row_addr            row currently displayed
//   frame_done          one-cycle pulse after the last latch of a frame
//   load_error          sticky loader timeout flag (0 without BCM_LOAD_TIMEOUT_EN)
module bcm_scan_ctrl #(
  parameter int ROWS          = 16,
  parameter int BITS          = 12,
  parameter int BYTES_PER_ROW = 8,
  parameter int BASE_TICKS    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [10:0]             frame_offset,
  output logic                    ld_load_rq,
  output logic [3:0]              ld_bit,
  output logic [10:0]             ld_address,
  input  logic                    ld_data_ready,
  input  logic [7:0]              ld_data_out,
  output logic                    sclk,
  output logic                    sdata,
  output logic                    latch,
  output logic                    oe_n,
  output logic [$clog2(ROWS)-1:0] row_addr,
  output logic                    frame_done,
  output logic                    load_error
);

  localparam int RW = $clog2(ROWS);
  localparam int BW = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;
  localparam int TW = $clog2(BASE_TICKS) + BITS + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_LATCH = 3'd6;

  logic [2:0]    state_q;
  logic [RW-1:0] row_q;
  logic [3:0]    plane_q;
  logic [BW-1:0] byte_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shreg_q;
  logic [10:0]   off_q;
  logic          rdy_q;
  logic [RW-1:0] row_addr_q;
  logic          frame_done_q;
  logic          rdy_edge;
  logic [10:0]   pix_idx;

`ifdef BCM_LOAD_TIMEOUT_EN
  logic [5:0]    wdog_q;
  logic          load_error_q;
  assign load_error = load_error_q;
`else
  assign load_error = 1'b0;
`endif

  // Only a fresh rising edge counts; a level left high from earlier is ignored.
  assign rdy_edge = ld_data_ready & ~rdy_q;

  // Pixel index of the byte being fetched; the add wraps silently at 2048.
  assign pix_idx    = 11'(row_q) * 11'(BYTES_PER_ROW) + 11'(byte_q);
  assign ld_address = off_q + (pix_idx << 3);
  assign ld_bit     = plane_q;
  assign ld_load_rq = (state_q == S_REQ);

  // bit_cnt_q[0] selects the low/high half of each sclk period, [3:1] the bit.
  assign sclk  = (state_q == S_SHIFT) & bit_cnt_q[0];
  assign sdata = (state_q == S_SHIFT) & shreg_q[bit_cnt_q[3:1]];
  assign latch = (state_q == S_LATCH);

  // LATCH is only entered with the timer at zero, so oe_n is high in that cycle.
  assign oe_n       = (timer_q == '0);
  assign row_addr   = row_addr_q;
  assign frame_done = frame_done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      plane_q      <= '0;
      byte_q       <= '0;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      off_q        <= '0;
      rdy_q        <= 1'b0;
      row_addr_q   <= '0;
      frame_done_q <= 1'b0;
`ifdef BCM_LOAD_TIMEOUT_EN
      wdog_q       <= '0;
      load_error_q <= 1'b0;
`endif
    end else begin
      rdy_q        <= ld_data_ready;
      frame_done_q <= 1'b0;
      // The OE period runs independently of the FSM so loading overlaps display.
      if (timer_q != '0) begin
        timer_q <= timer_q - TW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (enable) begin
            off_q   <= frame_offset;
            row_q   <= '0;
            plane_q <= '0;
            byte_q  <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
`ifdef BCM_LOAD_TIMEOUT_EN
          wdog_q  <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (rdy_edge) begin
            shreg_q   <= ld_data_out;
            bit_cnt_q <= '0;
            state_q   <= S_SHIFT;
          end
`ifdef BCM_LOAD_TIMEOUT_EN
          else if (wdog_q == 6'h3f) begin
            load_error_q <= 1'b1;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            state_q      <= S_SHIFT;
          end else begin
            wdog_q <= wdog_q + 6'd1;
          end
`endif
        end
        S_SHIFT: begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (byte_q != BW'(BYTES_PER_ROW - 1)) begin
            byte_q  <= byte_q + BW'(1);
            state_q <= S_REQ;
          end else begin
            byte_q  <= '0;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (timer_q == '0) begin
            state_q <= S_LATCH;
          end
        end
        S_LATCH: begin
          row_addr_q <= row_q;
          timer_q    <= TW'(BASE_TICKS) << plane_q;
          state_q    <= S_REQ;
          if (plane_q == 4'(BITS - 1)) begin
            plane_q <= '0;
            if (row_q == RW'(ROWS - 1)) begin
              row_q        <= '0;
              frame_done_q <= 1'b1;
              if (enable) begin
                off_q <= frame_offset;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              row_q <= row_q + RW'(1);
            end
          end else begin
            plane_q <= plane_q + 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcm_scan_ctrl.sv
// tb/tb_bcm_scan_ctrl.sv - randomized bench for bcm_scan_ctrl with a behavioural loader and scan model
module tb_bcm_scan_ctrl;

  localparam int ROWS = 2;
  localparam int BITS = 2;
  localparam int BPR  = 2;
  localparam int BASE = 4;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    enable;
  logic [10:0]             frame_offset;
  logic                    ld_load_rq;
  logic [3:0]              ld_bit;
  logic [10:0]             ld_address;
  logic                    ld_data_ready = 1'b0;
  logic [7:0]              ld_data_out = 8'h00;
  logic                    sclk;
  logic                    sdata;
  logic                    latch;
  logic                    oe_n;
  logic [$clog2(ROWS)-1:0] row_addr;
  logic                    frame_done;
  logic                    load_error;

  bcm_scan_ctrl #(
    .ROWS(ROWS), .BITS(BITS), .BYTES_PER_ROW(BPR), .BASE_TICKS(BASE)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .frame_offset(frame_offset),
    .ld_load_rq(ld_load_rq), .ld_bit(ld_bit), .ld_address(ld_address),
    .ld_data_ready(ld_data_ready), .ld_data_out(ld_data_out),
    .sclk(sclk), .sdata(sdata), .latch(latch), .oe_n(oe_n),
    .row_addr(row_addr), .frame_done(frame_done), .load_error(load_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // model state
  int cyc = 0, last_rq = -100, req_count = 0, frames = 0, latches = 0;
  int pending = 0, hold = 0, bitpos = 0, oe_cnt = 0, exp_len = 0, exp_row = 0;
  int m_row = 0, m_plane = 0, m_byte = 0, l_row = 0, l_plane = 0;
  int last_addr = 0, last_bit = 0, r0b1_addr = 0, ea = 0;
  logic [10:0] cur_off = '0;
  logic m_idle = 1'b1, measuring = 1'b0, row_chk = 1'b0, fd_exp = 1'b0;
  logic prev_sclk = 1'b0, first_byte = 1'b1, silent = 1'b0;
  logic [7:0] shbyte = '0, b = '0;
  logic [7:0] exp_bytes[$];
  int addr_log[$];
  int bit_log[$];

  // Loader model plus scan checker, all evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        m_row = 0; m_plane = 0; m_byte = 0; l_row = 0; l_plane = 0;
        exp_bytes.delete(); bitpos = 0; pending = 0; hold = 0;
        ld_data_ready = 1'b0; measuring = 1'b0; row_chk = 1'b0; fd_exp = 1'b0;
        m_idle = 1'b1; prev_sclk = 1'b0; last_rq = -100;
      end else begin
        if (frame_done || fd_exp) chk("frame_done", frame_done, fd_exp);
        fd_exp = 1'b0;
        if (frame_done) begin
          frames++;
          if (enable) cur_off = frame_offset;
          else m_idle = 1'b1;
        end

        // loader: raise ready after the chosen latency, drop it after a short hold
        if (ld_data_ready) begin
          if (hold == 0) ld_data_ready = 1'b0;
          else hold--;
        end else if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            b = first_byte ? 8'hA5 : 8'($urandom);
            first_byte = 1'b0;
            ld_data_out = b;
            ld_data_ready = 1'b1;
            hold = int'($urandom_range(0, 2));
            exp_bytes.push_back(b);
          end
        end

        if (ld_load_rq) begin
          chk("rq_gap", (cyc - last_rq) >= 3, 1);
          if (m_idle) begin
            cur_off = frame_offset;
            m_idle = 1'b0;
          end
          ea = (int'(cur_off) + (m_row * BPR + m_byte) * 8) % 2048;
          chk("ld_address", ld_address, ea);
          chk("ld_bit", ld_bit, m_plane);
          addr_log.push_back(int'(ld_address));
          bit_log.push_back(int'(ld_bit));
          last_addr = int'(ld_address);
          last_bit = int'(ld_bit);
          if (m_row == 0 && m_byte == 1) r0b1_addr = int'(ld_address);
          m_byte++;
          if (m_byte == BPR) begin
            m_byte = 0;
            m_plane++;
            if (m_plane == BITS) begin
              m_plane = 0;
              m_row = (m_row + 1) % ROWS;
            end
          end
          if (silent) exp_bytes.push_back(8'h00);
          else pending = int'($urandom_range(2, 12));
          last_rq = cyc;
          req_count++;
        end

        if (sclk) begin
          chk("sclk_single", prev_sclk, 0);
          shbyte[bitpos] = sdata;
          bitpos++;
          if (bitpos == 8) begin
            chk("byte_expected", exp_bytes.size() > 0, 1);
            if (exp_bytes.size() > 0) chk("shift_byte", shbyte, exp_bytes.pop_front());
            bitpos = 0;
          end
          // stray ready pulse while shifting must be ignored
          if (bitpos == 3 && !ld_data_ready && pending == 0 && !silent &&
              $urandom_range(0, 3) == 0) begin
            ld_data_out = 8'($urandom);
            ld_data_ready = 1'b1;
            hold = 0;
          end
        end
        prev_sclk = sclk;

        if (latch) begin
          chk("oe_n_at_latch", oe_n, 1);
          if (measuring) chk("oe_len", oe_cnt, exp_len);
          measuring = 1'b1;
          row_chk = 1'b1;
          oe_cnt = 0;
          exp_len = BASE << l_plane;
          exp_row = l_row;
          if (l_row == ROWS - 1 && l_plane == BITS - 1) fd_exp = 1'b1;
          l_plane++;
          if (l_plane == BITS) begin
            l_plane = 0;
            l_row = (l_row + 1) % ROWS;
          end
          latches++;
        end else if (measuring) begin
          if (row_chk) begin
            chk("row_addr", row_addr, exp_row);
            row_chk = 1'b0;
          end
          if (!oe_n) oe_cnt++;
          else begin
            chk("oe_len", oe_cnt, exp_len);
            measuring = 1'b0;
          end
        end else if (!oe_n) begin
          chk("oe_n_idle", oe_n, 1);
        end
      end
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int target;
    target = frames + n;
    while (frames < target && budget > 0) begin
      @(negedge clock); #1;
      budget--;
    end
    chk("frame_wait", frames, target);
  endtask

  task automatic wait_rq(input int budget);
    int r;
    r = req_count;
    while (req_count == r && budget > 0) begin
      @(negedge clock); #1;
      budget--;
    end
    chk("rq_wait", req_count != r, 1);
  endtask

  int exp_addr_tbl[8] = '{0, 8, 0, 8, 16, 24, 16, 24};
  int exp_bit_tbl[8]  = '{0, 0, 1, 1, 0, 0, 1, 1};
  int r0, t0, d, budget;

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    frame_offset = 11'h000;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_oe_n", oe_n, 1);
    chk("rst_rq", ld_load_rq, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_latch", latch, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_row_addr", row_addr, 0);
    chk("rst_ld_address", ld_address, 0);
    chk("rst_ld_bit", ld_bit, 0);
    chk("rst_load_error", load_error, 0);

    @(negedge clock);
    reset = 1'b0;
    enable = 1'b1;

    // frame 1: offset 0, first loader byte is A5
    wait_frames(1, 800);
    chk("latches_frame1", latches, ROWS * BITS);
    chk("addr_log_len", addr_log.size() >= 8, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < addr_log.size()) begin
        chk("addr_seq", addr_log[i], exp_addr_tbl[i]);
        chk("bit_seq", bit_log[i], exp_bit_tbl[i]);
      end
    end

    // offset set during frame 2 applies from frame 3 and wraps row 0 byte 1
    frame_offset = 11'h7F8;
    wait_frames(1, 800);
    chk("r0b1_frame2", r0b1_addr, 8);
    frame_offset = 11'($urandom);
    wait_frames(1, 800);
    chk("wrap_r0b1", r0b1_addr, 0);

    for (int i = 0; i < 2; i++) begin
      frame_offset = 11'($urandom);
      wait_frames(1, 800);
    end

    // enable dropped mid-frame: frame completes, then scan idles
    enable = 1'b0;
    wait_frames(1, 800);
    r0 = req_count;
    repeat (60) @(negedge clock);
    #1;
    chk("idle_no_rq", req_count, r0);
    chk("idle_oe_n", oe_n, 1);
    frame_offset = 11'($urandom);
    enable = 1'b1;
    wait_frames(1, 800);

    // reset in the middle of a shift
    budget = 400;
    while (!sclk && budget > 0) begin
      @(negedge clock); #1;
      budget--;
    end
    chk("reach_shift", sclk, 1);
    reset = 1'b1;
    #1;
    chk("rstmid_oe_n", oe_n, 1);
    chk("rstmid_sclk", sclk, 0);
    chk("rstmid_latch", latch, 0);
    chk("rstmid_rq", ld_load_rq, 0);
    chk("rstmid_frame_done", frame_done, 0);
    frame_offset = 11'($urandom);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_rq(50);
    chk("rst_first_addr", last_addr, frame_offset);
    chk("rst_first_bit", last_bit, 0);
    wait_frames(1, 800);

`ifdef BCM_LOAD_TIMEOUT_EN
    // silent loader: watchdog flags the error and shifts a zero byte
    @(posedge clock); #1;
    silent = 1'b1;
    wait_rq(100);
    silent = 1'b0;
    t0 = last_rq;
    d = cyc - t0;
    while (!load_error && d < 100) begin
      @(negedge clock); #1;
      d = cyc - t0;
    end
    chk("timeout_flag", load_error, 1);
    chk("timeout_latency", (d >= 60 && d <= 70), 1);
    wait_rq(60);
    wait_frames(1, 1000);
    chk("timeout_sticky", load_error, 1);
`else
    chk("load_error_off", load_error, 0);
`endif

    repeat (20) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
